// File: rtl/axil2wb_bridge.sv
// -----------------------------------------------------------------------------
// axil2wb_bridge
//
// AXI4-Lite responder that turns every AXI-Lite read or write into exactly one
// classic Wishbone master cycle. One transaction is in flight at a time. The
// AW, W and AR channels each have a 1-deep capture buffer, so a new request
// can be accepted while a Wishbone cycle runs. Contested grants alternate
// between write and read. A Wishbone slave that never answers is abandoned
// after TIMEOUT cycles and the bridge reports SLVERR.
//
// Ports:
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   awvalid/awready/awaddr        AXI write address channel
//   wvalid/wready/wdata/wstrb     AXI write data channel
//   bvalid/bready/bresp           AXI write response channel
//   arvalid/arready/araddr        AXI read address channel
//   rvalid/rready/rdata/rresp     AXI read data channel
//   wbm_cyc_o/stb_o/we_o          Wishbone master control
//   wbm_sel_o/adr_o/dat_o         Wishbone master request
//   wbm_dat_i/ack_i/err_i         Wishbone slave response
// -----------------------------------------------------------------------------
module axil2wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    axis_clk,
    input  logic                    axis_rst_n,

    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,

    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,

    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,

    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_WIDTH-1:0]   araddr,

    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,

    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    // The counter is compared before its increment, so matching TIMEOUT-1
    // means this is the TIMEOUT-th cycle spent waiting.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_WR,
        S_WB_RD,
        S_WRESP,
        S_RRESP
    } state_t;

    state_t state_q, state_d;

    // Capture buffers
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q,  w_full_d;
    logic                  ar_full_q, ar_full_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  arready_q, arready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;

    // Arbitration and Wishbone tracking
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            cnt_q, cnt_d;

    // Registered request / response datapath
    logic [ADDR_WIDTH-1:0] adr_q,   adr_d;
    logic [DATA_WIDTH-1:0] dat_q,   dat_d;
    logic [STRB_WIDTH-1:0] sel_q,   sel_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic wr_pend;
    logic rd_pend;
    logic grant_wr;
    logic grant_rd;
    logic wb_timeout;
    logic wb_done;
    logic wb_ok;

    assign wr_pend    = aw_full_q & w_full_q;
    assign rd_pend    = ar_full_q;
    assign wb_timeout = (cnt_q == TO_LAST);
    assign wb_done    = wbm_ack_i | wbm_err_i | wb_timeout;
    // Only a clean ack is OKAY; err (even alongside ack) or timeout is SLVERR.
    assign wb_ok      = wbm_ack_i & ~wbm_err_i;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state and arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (wr_pend && rd_pend) begin
                    // Round-robin only advances on a contested grant, so an
                    // uncontested request never steals the other side's turn.
                    if (last_grant_q == GRANT_RD) begin
                        grant_wr     = 1'b1;
                        last_grant_d = GRANT_WR;
                    end else begin
                        grant_rd     = 1'b1;
                        last_grant_d = GRANT_RD;
                    end
                end else if (wr_pend) begin
                    grant_wr = 1'b1;
                end else if (rd_pend) begin
                    grant_rd = 1'b1;
                end

                if (grant_wr) begin
                    state_d = S_WB_WR;
                end else if (grant_rd) begin
                    state_d = S_WB_RD;
                end
            end
            S_WB_WR: begin
                if (wb_done) begin
                    state_d = S_WRESP;
                end
            end
            S_WB_RD: begin
                if (wb_done) begin
                    state_d = S_RRESP;
                end
            end
            S_WRESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            S_RRESP: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from the state register (edge-aligned, stb == cyc)
    // -------------------------------------------------------------------------
    always_comb begin
        wbm_cyc_o = (state_q == S_WB_WR) || (state_q == S_WB_RD);
        wbm_stb_o = (state_q == S_WB_WR) || (state_q == S_WB_RD);
        wbm_we_o  = (state_q == S_WB_WR);
        bvalid    = (state_q == S_WRESP);
        rvalid    = (state_q == S_RRESP);
    end

    // -------------------------------------------------------------------------
    // Capture buffers and datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;

        // A buffer is never both captured into and launched from on one edge:
        // ready is low whenever the buffer is full.
        if (awvalid && awready_q) begin
            aw_full_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready_q) begin
            w_full_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (arvalid && arready_q) begin
            ar_full_d = 1'b1;
            araddr_d  = araddr;
        end
        if (grant_wr) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (grant_rd) begin
            ar_full_d = 1'b0;
        end

        // Ready is a register that mirrors the buffer's next emptiness, so it
        // drops the cycle after a handshake and rises again at the launch edge.
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
        arready_d = ~ar_full_d;
    end

    always_comb begin
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        bresp_d = bresp_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;

        if (grant_wr) begin
            cnt_d = 8'd0;
            adr_d = awaddr_q;
            dat_d = wdata_q;
            sel_d = wstrb_q;
        end else if (grant_rd) begin
            cnt_d = 8'd0;
            adr_d = araddr_q;
            sel_d = {STRB_WIDTH{1'b1}};
        end else if (state_q == S_WB_WR || state_q == S_WB_RD) begin
            cnt_d = cnt_q + 8'd1;
        end

        if (state_q == S_WB_WR && wb_done) begin
            bresp_d = wb_ok ? RESP_OKAY : RESP_SLVERR;
        end
        if (state_q == S_WB_RD && wb_done) begin
            rresp_d = wb_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_d = wb_ok ? wbm_dat_i : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            aw_full_q    <= 1'b0;
            w_full_q     <= 1'b0;
            ar_full_q    <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            araddr_q     <= '0;
            last_grant_q <= GRANT_RD;
            cnt_q        <= 8'd0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            bresp_q      <= RESP_OKAY;
            rresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
        end else begin
            aw_full_q    <= aw_full_d;
            w_full_q     <= w_full_d;
            ar_full_q    <= ar_full_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            arready_q    <= arready_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            araddr_q     <= araddr_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            bresp_q      <= bresp_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = wready_q;
    assign arready   = arready_q;
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_axil2wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil2wb_bridge
//
// Directed bench for axil2wb_bridge (TIMEOUT = 8). A small Wishbone slave
// model answers after a programmable number of wait cycles with ack, err,
// both or nothing. A negedge monitor records each Wishbone cycle's start
// count and length. Inputs are driven and outputs sampled on negedges.
// -----------------------------------------------------------------------------
module tb_axil2wb_bridge;

    logic        clk;
    logic        rst_n;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    axil2wb_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (8)
    ) dut (
        .axis_clk  (clk),
        .axis_rst_n(rst_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wishbone slave model: 0 = silent, 1 = ack, 2 = err, 3 = ack+err
    int          sl_mode;
    logic [7:0]  sl_wait;
    logic [31:0] sl_rdata;
    logic [7:0]  sl_cnt;

    always @(posedge clk) begin
        sl_cnt <= wbm_cyc_o ? sl_cnt + 8'd1 : 8'd0;
    end

    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (sl_cnt == sl_wait) && (sl_mode == 1 || sl_mode == 3);
    assign wbm_err_i = wbm_cyc_o && wbm_stb_o && (sl_cnt == sl_wait) && (sl_mode == 2 || sl_mode == 3);
    assign wbm_dat_i = sl_rdata;

    // Wishbone cycle monitor
    logic prev_cyc;
    int   wb_starts;
    int   cur_len;
    int   last_len;

    always @(negedge clk) begin
        if (wbm_cyc_o) begin
            if (!prev_cyc) begin
                wb_starts <= wb_starts + 1;
                cur_len   <= 1;
            end else begin
                cur_len <= cur_len + 1;
            end
        end else if (prev_cyc) begin
            last_len <= cur_len;
        end
        prev_cyc <= wbm_cyc_o;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for 0 = bvalid, 1 = rvalid, 2 = cyc; -1 on expiry.
    task automatic wait_for(input int which, input int bound, output int cycles);
        logic sig;
        cycles = -1;
        for (int i = 0; i < bound; i++) begin
            sig = (which == 0) ? bvalid : (which == 1) ? rvalid : wbm_cyc_o;
            if (sig) begin
                cycles = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    int   cyc_n;
    int   starts_ref;
    logic seen;

    initial begin
        rst_n = 1'b0;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
        bready = 0; arvalid = 0; araddr = 0; rready = 0;
        sl_mode = 1; sl_wait = 0; sl_rdata = 0;
        sl_cnt = 0; prev_cyc = 0; wb_starts = 0; cur_len = 0; last_len = 0;

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_outs", {26'd0, wready, bvalid, rvalid, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", {29'd0, awready, wready, arready}, 32'h7);

        // ---------------- single write ----------------
        awvalid = 1; awaddr = 32'h3000_0010;
        wvalid = 1; wdata = 32'h0000_0040; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        check("wr1_aw_drop", {30'd0, awready, wready}, 32'd0);
        check("wr1_no_cyc_yet", {31'd0, wbm_cyc_o}, 32'd0);
        tick();
        check("wr1_ctl", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h7);
        check("wr1_adr", wbm_adr_o, 32'h3000_0010);
        check("wr1_dat", wbm_dat_o, 32'h0000_0040);
        check("wr1_sel", {28'd0, wbm_sel_o}, 32'hF);
        check("wr1_ready_back", {30'd0, awready, wready}, 32'h3);
        tick();
        check("wr1_bvalid_2clk", {31'd0, bvalid}, 32'd1);
        check("wr1_bresp", {30'd0, bresp}, 32'd0);
        check("wr1_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
        bready = 1;
        tick();
        bready = 0;
        check("wr1_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("wr1_len", last_len, 32'd1);

        // ---------------- read with 3 wait states ----------------
        sl_wait = 3; sl_rdata = 32'h0000_0004;
        arvalid = 1; araddr = 32'h3000_0000;
        tick();
        arvalid = 0;
        wait_for(2, 10, cyc_n);
        check("rd2_cyc_seen", {31'd0, cyc_n != -1}, 32'd1);
        check("rd2_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'h0F);
        check("rd2_adr", wbm_adr_o, 32'h3000_0000);
        wait_for(1, 20, cyc_n);
        check("rd2_rvalid_seen", {31'd0, cyc_n != -1}, 32'd1);
        check("rd2_rdata", rdata, 32'h0000_0004);
        check("rd2_rresp", {30'd0, rresp}, 32'd0);
        seen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!rvalid || rdata !== 32'h4) seen = 1'b0;
        end
        check("rd2_rvalid_held", {31'd0, seen}, 32'd1);
        check("rd2_cyc_len", last_len, 32'd4);
        rready = 1;
        tick();
        rready = 0;
        check("rd2_rvalid_drop", {31'd0, rvalid}, 32'd0);

        // ---------------- split write: W leads AW by 4 cycles ----------------
        sl_wait = 0;
        starts_ref = wb_starts;
        wvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'h3;
        tick();
        wvalid = 0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wready || wbm_cyc_o) seen = 1'b1;
            tick();
        end
        check("split_wait", {31'd0, seen}, 32'd0);
        check("split_no_start", wb_starts, starts_ref);
        awvalid = 1; awaddr = 32'h3000_0080;
        tick();
        awvalid = 0;
        check("split_wready_low", {31'd0, wready}, 32'd0);
        tick();
        check("split_cyc", {30'd0, wbm_cyc_o, wbm_we_o}, 32'h3);
        check("split_sel", {28'd0, wbm_sel_o}, 32'h3);
        check("split_dat", wbm_dat_o, 32'hDEAD_BEEF);
        check("split_adr", wbm_adr_o, 32'h3000_0080);
        check("split_wready_back", {31'd0, wready}, 32'd1);
        wait_for(0, 10, cyc_n);
        check("split_bresp", {29'd0, bvalid, bresp}, 32'h4);
        bready = 1;
        tick();
        bready = 0;

        // ---------------- contention after a fresh reset ----------------
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        sl_rdata = 32'hAAAA_5555;
        awvalid = 1; awaddr = 32'h3000_0100; wvalid = 1; wdata = 32'h11; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h3000_0200;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("cont1_all_full", {29'd0, awready, wready, arready}, 32'd0);
        tick();
        check("cont1_first_is_wr", {31'd0, wbm_we_o}, 32'd1);
        check("cont1_wr_adr", wbm_adr_o, 32'h3000_0100);
        wait_for(0, 10, cyc_n);
        bready = 1;
        tick();
        bready = 0;
        wait_for(2, 10, cyc_n);
        check("cont1_second_is_rd", {31'd0, wbm_cyc_o, wbm_we_o}, 32'h2);
        check("cont1_rd_adr", wbm_adr_o, 32'h3000_0200);
        wait_for(1, 10, cyc_n);
        check("cont1_rdata", rdata, 32'hAAAA_5555);
        rready = 1;
        tick();
        rready = 0;

        awvalid = 1; awaddr = 32'h3000_0300; wvalid = 1; wdata = 32'h22; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h3000_0400;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        wait_for(2, 10, cyc_n);
        check("cont2_first_is_rd", {31'd0, wbm_cyc_o, wbm_we_o}, 32'h2);
        check("cont2_rd_adr", wbm_adr_o, 32'h3000_0400);
        wait_for(1, 10, cyc_n);
        rready = 1;
        tick();
        rready = 0;
        wait_for(2, 10, cyc_n);
        check("cont2_second_is_wr", {31'd0, wbm_cyc_o, wbm_we_o}, 32'h3);
        check("cont2_wr_dat", wbm_dat_o, 32'h22);
        wait_for(0, 10, cyc_n);
        bready = 1;
        tick();
        bready = 0;

        // ---------------- error write ----------------
        sl_mode = 2;
        awvalid = 1; awaddr = 32'h3000_0500; wvalid = 1; wdata = 32'h33; wstrb = 4'hF;
        tick();
        awvalid = 0; wvalid = 0;
        wait_for(0, 10, cyc_n);
        check("err_wr_bresp", {29'd0, bvalid, bresp}, 32'h6);
        bready = 1;
        tick();
        bready = 0;

        // ---------------- ack+err read: err wins ----------------
        sl_mode = 3; sl_rdata = 32'h5A5A_0001;
        arvalid = 1; araddr = 32'h3000_0700;
        tick();
        arvalid = 0;
        wait_for(1, 10, cyc_n);
        check("both_rresp", {29'd0, rvalid, rresp}, 32'h6);
        check("both_rdata", rdata, 32'd0);
        rready = 1;
        tick();
        rready = 0;

        // ---------------- timeout read (TIMEOUT = 8) ----------------
        sl_mode = 0;
        arvalid = 1; araddr = 32'h3000_0600;
        tick();
        arvalid = 0;
        wait_for(1, 30, cyc_n);
        check("to_rresp", {29'd0, rvalid, rresp}, 32'h6);
        check("to_rdata", rdata, 32'd0);
        rready = 1;
        tick();
        rready = 0;
        check("to_cyc_len", last_len, 32'd8);

        // ---------------- reset in the middle of a read ----------------
        arvalid = 1; araddr = 32'h3000_0800;
        tick();
        arvalid = 0;
        wait_for(2, 10, cyc_n);
        tick();
        check("mid_cyc_before", {31'd0, wbm_cyc_o}, 32'd1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_outs", {27'd0, wbm_cyc_o, wbm_stb_o, rvalid, arready, bvalid}, 32'd0);
        tick();
        rst_n = 1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rvalid || wbm_cyc_o) seen = 1'b1;
        end
        check("mid_no_resp", {31'd0, seen}, 32'd0);
        sl_mode = 1; sl_wait = 1; sl_rdata = 32'h1234_5678;
        arvalid = 1; araddr = 32'h3000_0900;
        tick();
        arvalid = 0;
        wait_for(1, 20, cyc_n);
        check("post_rst_rd", {29'd0, rvalid, rresp}, 32'h4);
        check("post_rst_rdata", rdata, 32'h1234_5678);
        rready = 1;
        tick();
        rready = 0;
        check("post_rst_len", last_len, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
